// File: rtl/tone_detector.sv
// tone_detector: locks onto a square-wave tone of known half-period and reports completed bursts
module tone_detector #(
  parameter int HALF_PERIOD = 32769,
  parameter int TOL = 512,
  parameter int MIN_HALVES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JB,
  output logic        tone_active,
  output logic        burst_pulse,
  output logic [7:0]  burst_count,
  output logic [9:0]  burst_len,
  output logic [16:0] half_period
);
  localparam logic [16:0] TIMEOUT = 17'(HALF_PERIOD + TOL + 1);
  localparam logic [17:0] LO = 18'(HALF_PERIOD - TOL);
  localparam logic [17:0] HI = 18'(HALF_PERIOD + TOL);
  localparam logic [9:0] LOCK_N = 10'(MIN_HALVES);
  typedef enum logic [1:0] {IDLE, LOCKING, ACTIVE} state_t;
  state_t state, state_n;
  logic sync1, sync2, prev;
  logic [16:0] counter;
  logic [9:0] match_cnt, match_cnt_n, run_len, run_len_n;
  logic tone_n, burst_end, edge_det, timeout, match;
  logic [17:0] measured;
  assign edge_det = sync2 ^ prev;
  assign measured = {1'b0, counter} + 18'd1;
  assign match = measured >= LO && measured <= HI;
  // fires only on the step into saturation, so a quiet line times out once
  assign timeout = !edge_det && counter == TIMEOUT - 17'd1;
  // input synchronizer, interval counter and half-period capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev <= 1'b0;
      counter <= '0;
      half_period <= '0;
    end else begin
      sync1 <= JB;
      sync2 <= sync1;
      prev <= sync2;
      counter <= edge_det ? '0 : counter == TIMEOUT ? counter : counter + 17'd1;
      if (edge_det && state != IDLE) half_period <= counter + 17'd1;
    end
  end
  // lock tracking: next state, match/run counters and burst end detection
  always_comb begin
    state_n = state;
    match_cnt_n = match_cnt;
    run_len_n = run_len;
    tone_n = tone_active;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_n = LOCKING;
          match_cnt_n = '0;
        end
      end
      LOCKING: begin
        if (edge_det && match && match_cnt + 10'd1 == LOCK_N) begin
          state_n = ACTIVE;
          run_len_n = LOCK_N;
          tone_n = 1'b1;
        end else if (edge_det) begin
          match_cnt_n = match ? match_cnt + 10'd1 : '0;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (edge_det && match) begin
          run_len_n = run_len == 10'd1023 ? run_len : run_len + 10'd1;
        end else if (edge_det || timeout) begin
          state_n = edge_det ? LOCKING : IDLE;
          match_cnt_n = '0;
          tone_n = 1'b0;
          burst_end = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state register and registered burst reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      match_cnt <= '0;
      run_len <= '0;
      tone_active <= 1'b0;
      burst_pulse <= 1'b0;
      burst_count <= '0;
      burst_len <= '0;
    end else begin
      state <= state_n;
      match_cnt <= match_cnt_n;
      run_len <= run_len_n;
      tone_active <= tone_n;
      burst_pulse <= burst_end;
      if (burst_end) begin
        burst_count <= burst_count + 8'd1;
        burst_len <= run_len;
      end
    end
  end
endmodule
